// File: rtl/frame_buffer_matrix3_scheduler_if.sv
// Handshake bundle between the pixel front end and the 3x3 matrix scheduler.
interface frame_buffer_matrix3_scheduler_if #(
  parameter int P_COLUMN_BITS = 10,
  parameter int P_ROW_BITS    = 9
);
  logic                     I_FRAME_START;
  logic                     I_PIXEL_VALID;
  logic                     I_LINE_END;
  logic                     O_WRITE_ENABLE;
  logic [P_COLUMN_BITS-1:0] O_WRITE_COLUMN;
  logic [1:0]               O_WRITE_SLOT;
  logic                     O_READ_ENABLE;
  logic [P_COLUMN_BITS-1:0] O_READ_COLUMN;
  logic [1:0]               O_READ_TOP_SLOT;
  logic [P_COLUMN_BITS-1:0] O_PIXEL_COLUMN;
  logic [P_ROW_BITS-1:0]    O_PIXEL_ROW;
  logic                     O_MATRIX_VALID;
  logic                     O_BUSY;
  logic                     O_ERROR;

  modport slave (
    input  I_FRAME_START, I_PIXEL_VALID, I_LINE_END,
    output O_WRITE_ENABLE, O_WRITE_COLUMN, O_WRITE_SLOT,
    output O_READ_ENABLE, O_READ_COLUMN, O_READ_TOP_SLOT,
    output O_PIXEL_COLUMN, O_PIXEL_ROW, O_MATRIX_VALID, O_BUSY, O_ERROR
  );

  modport master (
    output I_FRAME_START, I_PIXEL_VALID, I_LINE_END,
    input  O_WRITE_ENABLE, O_WRITE_COLUMN, O_WRITE_SLOT,
    input  O_READ_ENABLE, O_READ_COLUMN, O_READ_TOP_SLOT,
    input  O_PIXEL_COLUMN, O_PIXEL_ROW, O_MATRIX_VALID, O_BUSY, O_ERROR
  );
endinterface

// File: rtl/frame_buffer_matrix3_scheduler.sv
// 3x3 matrix scheduler over a three-line ring buffer: line-buffer writes, matrix reads, centre coordinates.
// Define FRAME_ERROR_DETECT_EN to enable the sticky framing-error flag on O_ERROR.
module frame_buffer_matrix3_scheduler #(
  parameter int P_FRAME_COLUMNS = 640,
  parameter int P_FRAME_ROWS    = 480,
  parameter int P_COLUMN_BITS   = $clog2(P_FRAME_COLUMNS),
  parameter int P_ROW_BITS      = $clog2(P_FRAME_ROWS)
) (
  input  logic                            I_CLK,
  input  logic                            I_RESET,
  frame_buffer_matrix3_scheduler_if.slave bus
);
  // Counters carry one extra bit so they can hold the saturated value P_FRAME_COLUMNS / P_FRAME_ROWS.
  localparam int COL_W = P_COLUMN_BITS + 1;
  localparam int ROW_W = P_ROW_BITS + 1;
  localparam logic [COL_W-1:0] LINE_LEN = COL_W'(P_FRAME_COLUMNS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(P_FRAME_ROWS - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  state_t                   state_q, state_d;
  logic [COL_W-1:0]         column_q, column_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [1:0]               slot_q, slot_d;
  logic                     wr_en_q, wr_en_d;
  logic [P_COLUMN_BITS-1:0] wr_col_q, wr_col_d;
  logic [1:0]               wr_slot_q, wr_slot_d;
  logic                     rd_en_q, rd_en_d;
  logic [P_COLUMN_BITS-1:0] rd_col_q, rd_col_d;
  logic [1:0]               rd_slot_q, rd_slot_d;
  logic [P_COLUMN_BITS-1:0] ctr_col_q, ctr_col_d;
  logic [P_ROW_BITS-1:0]    ctr_row_q, ctr_row_d;
  logic                     mx_valid_q, mx_valid_d;
  logic [P_COLUMN_BITS-1:0] pix_col_q, pix_col_d;
  logic [P_ROW_BITS-1:0]    pix_row_q, pix_row_d;

  logic             active;
  logic             accept;
  logic [COL_W-1:0] column_after;

  assign active       = (state_q == FILL) || (state_q == STREAM);
  assign accept       = active && bus.I_PIXEL_VALID && (column_q < LINE_LEN);
  assign column_after = accept ? column_q + COL_W'(1) : column_q;

  // NOTE: every *_d signal is given a default before any branch, so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    column_d   = column_q;
    row_d      = row_q;
    slot_d     = slot_q;
    wr_en_d    = 1'b0;
    wr_col_d   = wr_col_q;
    wr_slot_d  = wr_slot_q;
    rd_en_d    = 1'b0;
    rd_col_d   = rd_col_q;
    rd_slot_d  = rd_slot_q;
    ctr_col_d  = ctr_col_q;
    ctr_row_d  = ctr_row_q;
    mx_valid_d = rd_en_q && !bus.I_FRAME_START;
    pix_col_d  = rd_en_q ? ctr_col_q : pix_col_q;
    pix_row_d  = rd_en_q ? ctr_row_q : pix_row_q;

    if (bus.I_FRAME_START) begin
      state_d  = FILL;
      column_d = '0;
      row_d    = '0;
      slot_d   = '0;
    end else begin
      // Pixel is handled at the old column/slot before any coincident line end.
      if (accept) begin
        wr_en_d   = 1'b1;
        wr_col_d  = column_q[P_COLUMN_BITS-1:0];
        wr_slot_d = slot_q;
        column_d  = column_after;
        if ((state_q == STREAM) && (column_q >= COL_W'(2))) begin
          rd_en_d   = 1'b1;
          rd_col_d  = column_q[P_COLUMN_BITS-1:0];
          rd_slot_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
          ctr_col_d = P_COLUMN_BITS'(column_q - COL_W'(1));
          ctr_row_d = P_ROW_BITS'(row_q - ROW_W'(1));
        end
      end

      if (active && bus.I_LINE_END) begin
        column_d = '0;
        slot_d   = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
        row_d    = row_q + ROW_W'(1);
        if ((state_q == FILL) && (row_q != '0)) begin
          state_d = STREAM;
        end else if ((state_q == STREAM) && (row_q >= LAST_ROW)) begin
          state_d = DONE;
        end
      end

      if (state_q == DONE) begin
        state_d = IDLE;
      end
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the pre-edge value of its peers.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q    <= IDLE;
      column_q   <= '0;
      row_q      <= '0;
      slot_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_col_q   <= '0;
      wr_slot_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_col_q   <= '0;
      rd_slot_q  <= '0;
      ctr_col_q  <= '0;
      ctr_row_q  <= '0;
      mx_valid_q <= 1'b0;
      pix_col_q  <= '0;
      pix_row_q  <= '0;
    end else begin
      state_q    <= state_d;
      column_q   <= column_d;
      row_q      <= row_d;
      slot_q     <= slot_d;
      wr_en_q    <= wr_en_d;
      wr_col_q   <= wr_col_d;
      wr_slot_q  <= wr_slot_d;
      rd_en_q    <= rd_en_d;
      rd_col_q   <= rd_col_d;
      rd_slot_q  <= rd_slot_d;
      ctr_col_q  <= ctr_col_d;
      ctr_row_q  <= ctr_row_d;
      mx_valid_q <= mx_valid_d;
      pix_col_q  <= pix_col_d;
      pix_row_q  <= pix_row_d;
    end
  end

`ifdef FRAME_ERROR_DETECT_EN
  logic error_q, error_d;

  // Sticky until the next frame start: dropped pixel, or a line end on a short/long line.
  always_comb begin
    error_d = error_q;
    if (bus.I_FRAME_START) begin
      error_d = 1'b0;
    end else if (active && ((bus.I_PIXEL_VALID && !accept) ||
                            (bus.I_LINE_END && (column_after != LINE_LEN)))) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign bus.O_ERROR = error_q;
`else
  assign bus.O_ERROR = 1'b0;
`endif

  assign bus.O_WRITE_ENABLE  = wr_en_q;
  assign bus.O_WRITE_COLUMN  = wr_col_q;
  assign bus.O_WRITE_SLOT    = wr_slot_q;
  assign bus.O_READ_ENABLE   = rd_en_q;
  assign bus.O_READ_COLUMN   = rd_col_q;
  assign bus.O_READ_TOP_SLOT = rd_slot_q;
  assign bus.O_MATRIX_VALID  = mx_valid_q;
  assign bus.O_PIXEL_COLUMN  = pix_col_q;
  assign bus.O_PIXEL_ROW     = pix_row_q;
  assign bus.O_BUSY          = (state_q != IDLE);
endmodule

// File: tb/tb_frame_buffer_matrix3_scheduler.sv
// Self-checking bench: scoreboard queues for write/read/matrix commands plus a per-cycle vector table.
module tb_frame_buffer_matrix3_scheduler;
  localparam int COLS = 8;
  localparam int ROWS = 4;
`ifdef FRAME_ERROR_DETECT_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  typedef struct {
    bit fs, pv, le;
    bit busy, we, re;
    int wcol, wslot;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_buffer_matrix3_scheduler_if #(.P_COLUMN_BITS(3), .P_ROW_BITS(2)) bus ();

  frame_buffer_matrix3_scheduler #(
    .P_FRAME_COLUMNS(COLS),
    .P_FRAME_ROWS   (ROWS)
  ) dut (
    .I_CLK  (clk),
    .I_RESET(rst),
    .bus    (bus)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  pair_t wr_q[$];
  pair_t rd_q[$];
  pair_t mx_q[$];
  int    wr_count, rd_count, mx_count;
  pair_t first_mx, last_mx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic pair_t mk(input int a, input int b);
    return '{a: 8'(a), b: 8'(b)};
  endfunction

  // Scoreboard: every enable pulse pops and compares the oldest expected command.
  always @(negedge clk) begin
    if (bus.O_WRITE_ENABLE === 1'b1) begin
      pair_t e;
      wr_count++;
      check("write_expected", 32'(wr_q.size() != 0), 1);
      if (wr_q.size() != 0) begin
        e = wr_q.pop_front();
        check("write_column", 32'(bus.O_WRITE_COLUMN), 32'(e.a));
        check("write_slot", 32'(bus.O_WRITE_SLOT), 32'(e.b));
      end
    end
    if (bus.O_READ_ENABLE === 1'b1) begin
      pair_t e;
      rd_count++;
      check("read_expected", 32'(rd_q.size() != 0), 1);
      if (rd_q.size() != 0) begin
        e = rd_q.pop_front();
        check("read_column", 32'(bus.O_READ_COLUMN), 32'(e.a));
        check("read_top_slot", 32'(bus.O_READ_TOP_SLOT), 32'(e.b));
      end
    end
    if (bus.O_MATRIX_VALID === 1'b1) begin
      pair_t e;
      if (mx_count == 0) first_mx = mk(int'(bus.O_PIXEL_COLUMN), int'(bus.O_PIXEL_ROW));
      last_mx = mk(int'(bus.O_PIXEL_COLUMN), int'(bus.O_PIXEL_ROW));
      mx_count++;
      check("matrix_expected", 32'(mx_q.size() != 0), 1);
      if (mx_q.size() != 0) begin
        e = mx_q.pop_front();
        check("pixel_column", 32'(bus.O_PIXEL_COLUMN), 32'(e.a));
        check("pixel_row", 32'(bus.O_PIXEL_ROW), 32'(e.b));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    wr_count = 0;
    rd_count = 0;
    mx_count = 0;
  endtask

  task automatic start_frame();
    bus.I_FRAME_START = 1'b1;
    tick();
    bus.I_FRAME_START = 1'b0;
  endtask

  // end_mode: 0 = no line end, 1 = line end two idle cycles after the last pixel, 2 = with the last pixel.
  task automatic send_line(input int line, input int npix, input int end_mode);
    for (int c = 0; c < npix; c++) begin
      if (c < COLS) begin
        wr_q.push_back(mk(c, line % 3));
        if (line >= 2 && c >= 2) begin
          rd_q.push_back(mk(c, (line + 1) % 3));
          mx_q.push_back(mk(c - 1, line - 1));
        end
      end
      bus.I_PIXEL_VALID = 1'b1;
      bus.I_LINE_END    = (end_mode == 2) && (c == npix - 1);
      tick();
    end
    bus.I_PIXEL_VALID = 1'b0;
    bus.I_LINE_END    = 1'b0;
    if (end_mode == 1) begin
      tick();
      tick();
      bus.I_LINE_END = 1'b1;
      tick();
      bus.I_LINE_END = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outputs_zero"},
          32'({bus.O_WRITE_ENABLE, bus.O_WRITE_COLUMN, bus.O_WRITE_SLOT, bus.O_READ_ENABLE,
               bus.O_READ_COLUMN, bus.O_READ_TOP_SLOT, bus.O_PIXEL_COLUMN, bus.O_PIXEL_ROW,
               bus.O_MATRIX_VALID, bus.O_ERROR}), 0);
    check({tag, "_busy"}, 32'(bus.O_BUSY), 0);
  endtask

  task automatic full_frame(input string tag);
    clear_counts();
    start_frame();
    check({tag, "_busy_after_start"}, 32'(bus.O_BUSY), 1);
    for (int l = 0; l < ROWS; l++) begin
      send_line(l, COLS, 1);
      if (l == 1) begin
        check({tag, "_fill_writes"}, 32'(wr_count), 16);
        check({tag, "_fill_reads"}, 32'(rd_count), 0);
      end
    end
    check({tag, "_busy_in_done"}, 32'(bus.O_BUSY), 1);
    tick();
    check({tag, "_busy_after_done"}, 32'(bus.O_BUSY), 0);
    check({tag, "_writes"}, 32'(wr_count), 32);
    check({tag, "_reads"}, 32'(rd_count), 12);
    check({tag, "_matrix_pulses"}, 32'(mx_count), 12);
    check({tag, "_first_centre"}, 32'(first_mx), 32'(mk(1, 1)));
    check({tag, "_last_centre"}, 32'(last_mx), 32'(mk(6, 2)));
  endtask

  vec_t tbl[13];

  initial begin
    // Per-cycle vectors: ignored strobes in IDLE, a frame start, then pixel + line end on column 7.
    tbl[0] = '{fs: 0, pv: 1, le: 0, busy: 0, we: 0, re: 0, wcol: 0, wslot: 0};
    tbl[1] = '{fs: 0, pv: 0, le: 1, busy: 0, we: 0, re: 0, wcol: 0, wslot: 0};
    tbl[2] = '{fs: 1, pv: 0, le: 0, busy: 1, we: 0, re: 0, wcol: 0, wslot: 0};
    for (int c = 0; c < 7; c++)
      tbl[3+c] = '{fs: 0, pv: 1, le: 0, busy: 1, we: 1, re: 0, wcol: c, wslot: 0};
    tbl[10] = '{fs: 0, pv: 1, le: 1, busy: 1, we: 1, re: 0, wcol: 7, wslot: 0};
    tbl[11] = '{fs: 0, pv: 1, le: 0, busy: 1, we: 1, re: 0, wcol: 0, wslot: 1};
    tbl[12] = '{fs: 0, pv: 0, le: 0, busy: 1, we: 0, re: 0, wcol: 0, wslot: 0};

    bus.I_FRAME_START = 1'b0;
    bus.I_PIXEL_VALID = 1'b0;
    bus.I_LINE_END    = 1'b0;
    clear_counts();
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle");

    // Full frame: FILL writes, STREAM reads, slot rotation, centre coordinates, DONE -> IDLE.
    full_frame("frame");

    // Overlong line: saturation and (optionally) sticky error; short line end also flags it.
    clear_counts();
    start_frame();
    send_line(0, 10, 1);
    check("overlong_writes", 32'(wr_count), 8);
    check("overlong_error", 32'(bus.O_ERROR), 32'(EXP_ERR));
    tick();
    tick();
    check("error_sticky", 32'(bus.O_ERROR), 32'(EXP_ERR));
    start_frame();
    check("error_cleared", 32'(bus.O_ERROR), 0);
    send_line(0, 3, 1);
    check("short_line_error", 32'(bus.O_ERROR), 32'(EXP_ERR));
    start_frame();
    check("error_cleared_again", 32'(bus.O_ERROR), 0);

    // Reset mid-STREAM: outputs zero next cycle, in-flight matrix output dropped, then a clean frame.
    start_frame();
    send_line(0, COLS, 1);
    send_line(1, COLS, 1);
    send_line(2, 5, 0);
    rst = 1'b1;
    bus.I_PIXEL_VALID = 1'b1;
    tick();
    rst = 1'b0;
    bus.I_PIXEL_VALID = 1'b0;
    check_all_zero("mid_stream_reset");
    check("reset_dropped_matrix", 32'(mx_q.size()), 1);
    check("reset_pending_writes", 32'(wr_q.size() + rd_q.size()), 0);
    mx_q.delete();
    tick();
    full_frame("after_reset");

    // Frame start mid-STREAM: counters restart, no matrix output until line 2 of the new frame.
    start_frame();
    send_line(0, COLS, 1);
    send_line(1, COLS, 1);
    send_line(2, 4, 0);
    tick();
    tick();
    clear_counts();
    start_frame();
    check("restart_busy", 32'(bus.O_BUSY), 1);
    send_line(0, COLS, 1);
    send_line(1, COLS, 1);
    check("restart_no_matrix", 32'(mx_count), 0);
    send_line(2, COLS, 1);
    send_line(3, COLS, 1);
    tick();
    check("restart_matrix", 32'(mx_count), 12);
    check("restart_idle", 32'(bus.O_BUSY), 0);

    // Table-driven per-cycle checks.
    for (int i = 0; i < 13; i++) begin
      bus.I_FRAME_START = tbl[i].fs;
      bus.I_PIXEL_VALID = tbl[i].pv;
      bus.I_LINE_END    = tbl[i].le;
      if (tbl[i].we) wr_q.push_back(mk(tbl[i].wcol, tbl[i].wslot));
      tick();
      check($sformatf("vec%0d_busy", i), 32'(bus.O_BUSY), 32'(tbl[i].busy));
      check($sformatf("vec%0d_write_enable", i), 32'(bus.O_WRITE_ENABLE), 32'(tbl[i].we));
      check($sformatf("vec%0d_read_enable", i), 32'(bus.O_READ_ENABLE), 32'(tbl[i].re));
    end
    bus.I_FRAME_START = 1'b0;
    bus.I_PIXEL_VALID = 1'b0;
    bus.I_LINE_END    = 1'b0;
    tick();
    tick();

    check("write_queue_drained", 32'(wr_q.size()), 0);
    check("read_queue_drained", 32'(rd_q.size()), 0);
    check("matrix_queue_drained", 32'(mx_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
